// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and default dimensions used by the flattener,
// pooling stage and unflattener.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } unflatten_state_t;

  localparam int DEF_NUM_FEATURES  = 2;
  localparam int DEF_POOLED_HEIGHT = 4;
  localparam int DEF_POOLED_WIDTH  = 4;
  localparam int DEF_CONV_DATA_W   = 8;

  function automatic int flattened_length(input int nf, input int h, input int w);
    return nf * h * w;
  endfunction

endpackage

// File: rtl/unflatten_index_counter.sv
// Cascaded col/row/feature wrap counters walking a feature map in flattener order.
module unflatten_index_counter #(
  parameter int NUM_FEATURES  = 2,
  parameter int POOLED_HEIGHT = 4,
  parameter int POOLED_WIDTH  = 4,
  localparam int FW = (NUM_FEATURES  > 1) ? $clog2(NUM_FEATURES)  : 1,
  localparam int RW = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1,
  localparam int CW = (POOLED_WIDTH  > 1) ? $clog2(POOLED_WIDTH)  : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          advance,
  output logic [FW-1:0] feature,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [FW-1:0] FEAT_MAX = FW'(NUM_FEATURES - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(POOLED_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(POOLED_WIDTH - 1);

  assign last = (feature == FEAT_MAX) && (row == ROW_MAX) && (col == COL_MAX);

  // clear has priority so a restart discards any advance in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      feature <= '0;
      row     <= '0;
      col     <= '0;
    end else if (clear) begin
      feature <= '0;
      row     <= '0;
      col     <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        if (row == ROW_MAX) begin
          row     <= '0;
          feature <= (feature == FEAT_MAX) ? '0 : feature + FW'(1);
        end else begin
          row <= row + RW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/unflatten_stream.sv
// Rebuilds a NUM_FEATURES x POOLED_HEIGHT x POOLED_WIDTH map from a serial
// flattened stream and holds it for the consumer until acknowledged.
module unflatten_stream
  import cnn_pkg::*;
#(
  parameter int NUM_FEATURES           = DEF_NUM_FEATURES,
  parameter int POOLED_HEIGHT          = DEF_POOLED_HEIGHT,
  parameter int POOLED_WIDTH           = DEF_POOLED_WIDTH,
  parameter int FLATTENED_LENGTH       = 32,
  parameter int CONVOLUTION_DATA_WIDTH = DEF_CONV_DATA_W
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                unflatten_start,
  input  logic [CONVOLUTION_DATA_WIDTH-1:0]   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [CONVOLUTION_DATA_WIDTH-1:0]   unflattened_outfmap [NUM_FEATURES][POOLED_HEIGHT][POOLED_WIDTH],
  output logic                                out_valid,
  input  logic                                out_ack,
  output logic [$clog2(FLATTENED_LENGTH+1)-1:0] element_count,
  output unflatten_state_t                    state
);

  localparam int CNT_W = $clog2(FLATTENED_LENGTH + 1);
  localparam int FW = (NUM_FEATURES  > 1) ? $clog2(NUM_FEATURES)  : 1;
  localparam int RW = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1;
  localparam int CW = (POOLED_WIDTH  > 1) ? $clog2(POOLED_WIDTH)  : 1;

  if (FLATTENED_LENGTH != flattened_length(NUM_FEATURES, POOLED_HEIGHT, POOLED_WIDTH)) begin : g_len_check
    $fatal(1, "FLATTENED_LENGTH does not equal NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
  end

  unflatten_state_t next_state;
  logic             clear;
  logic             advance;
  logic [FW-1:0]    feature;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic             last;

  // Handshakes: an element transfers on a rising edge where in_valid && in_ready;
  // the map transfers on a rising edge where out_valid && out_ack. Both ready
  // and valid are decoded from the state register only.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);

  unflatten_index_counter #(
    .NUM_FEATURES  (NUM_FEATURES),
    .POOLED_HEIGHT (POOLED_HEIGHT),
    .POOLED_WIDTH  (POOLED_WIDTH)
  ) u_index (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .advance (advance),
    .feature (feature),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (unflatten_start) begin
          next_state = FILL;
          clear      = 1'b1;
        end
      end
      FILL: begin
        // a start in FILL restarts and drops the element offered alongside it
        if (unflatten_start) begin
          clear = 1'b1;
        end else if (in_valid) begin
          advance = 1'b1;
          if (last) next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ack) begin
          if (unflatten_start) begin
            next_state = FILL;
            clear      = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      element_count <= '0;
    end else if (clear) begin
      element_count <= '0;
    end else if (advance && (element_count != CNT_W'(FLATTENED_LENGTH))) begin
      element_count <= element_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < NUM_FEATURES; f++)
        for (int r = 0; r < POOLED_HEIGHT; r++)
          for (int c = 0; c < POOLED_WIDTH; c++)
            unflattened_outfmap[f][r][c] <= '0;
    end else if (advance) begin
      unflattened_outfmap[feature][row][col] <= in_data;
    end
  end

endmodule
